// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the BRAM port A and mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/BRAM side.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_din;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_din;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_din,
    input  r1_req, r1_we, r1_addr, r1_din,
    input  mem_dout,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_addr, mem_din, mem_we
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_din,
    output r1_req, r1_we, r1_addr, r1_din,
    output mem_dout,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for BRAM port A with fully registered outputs.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to requester 0.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] mem_addr_r, mem_addr_s;
  logic [DW-1:0] mem_din_r, mem_din_s;
  logic          mem_we_r, mem_we_s;
  logic [1:0]    gnt_r, gnt_s;
  logic [1:0]    rvalid_r, rvalid_s;
  logic [DW-1:0] rdata0_r, rdata0_s;
  logic [DW-1:0] rdata1_r, rdata1_s;
  logic          owner_r, owner_s;
  logic          last_gnt_r, last_gnt_s;
  logic          busy_r;
  logic          win_s;

  // Next-state, winner selection and next values of every registered output.
  always_comb begin
    state_s    = state_r;
    mem_addr_s = mem_addr_r;
    mem_din_s  = mem_din_r;
    mem_we_s   = 1'b0;
    gnt_s      = 2'b00;
    rvalid_s   = 2'b00;
    rdata0_s   = rdata0_r;
    rdata1_s   = rdata1_r;
    owner_s    = owner_r;
    last_gnt_s = last_gnt_r;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    win_s = bus.r1_req & (~bus.r0_req | ~last_gnt_r);
`else
    win_s = ~bus.r0_req;
`endif

    case (state_r)
      IDLE: begin
        if (bus.r0_req | bus.r1_req) begin
          state_s    = ISSUE;
          owner_s    = win_s;
          last_gnt_s = win_s;
          if (win_s) begin
            mem_addr_s = bus.r1_addr;
            mem_din_s  = bus.r1_din;
            mem_we_s   = bus.r1_we;
            gnt_s      = 2'b10;
          end else begin
            mem_addr_s = bus.r0_addr;
            mem_din_s  = bus.r0_din;
            mem_we_s   = bus.r0_we;
            gnt_s      = 2'b01;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (mem_we_r) begin
          state_s = IDLE;
        end else begin
          state_s = CAPTURE;
        end
      end
      CAPTURE: begin
        // BRAM read data arrives one cycle after the address was presented in ISSUE.
        if (owner_r) begin
          rdata1_s = bus.mem_dout;
          rvalid_s = 2'b10;
        end else begin
          rdata0_s = bus.mem_dout;
          rvalid_s = 2'b01;
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mem_addr_r <= {AW{1'b0}};
      mem_din_r  <= {DW{1'b0}};
      mem_we_r   <= 1'b0;
      gnt_r      <= 2'b00;
      rvalid_r   <= 2'b00;
      rdata0_r   <= {DW{1'b0}};
      rdata1_r   <= {DW{1'b0}};
      owner_r    <= 1'b0;
      last_gnt_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      mem_addr_r <= mem_addr_s;
      mem_din_r  <= mem_din_s;
      mem_we_r   <= mem_we_s;
      gnt_r      <= gnt_s;
      rvalid_r   <= rvalid_s;
      rdata0_r   <= rdata0_s;
      rdata1_r   <= rdata1_s;
      owner_r    <= owner_s;
      last_gnt_r <= last_gnt_s;
      busy_r     <= (state_s != IDLE);
    end
  end

  assign bus.r0_gnt    = gnt_r[0];
  assign bus.r1_gnt    = gnt_r[1];
  assign bus.r0_rvalid = rvalid_r[0];
  assign bus.r1_rvalid = rvalid_r[1];
  assign bus.r0_rdata  = rdata0_r;
  assign bus.r1_rdata  = rdata1_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_din   = mem_din_r;
  assign bus.mem_we    = mem_we_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural BRAM.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_errors;

  logic        pre_en;
  logic [15:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [0:65535];

  mem_port_arbiter_if #(.AW(16), .DW(16)) bus ();

  mem_port_arbiter #(.AW(16), .DW(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM with one-cycle read latency, plus a backdoor preload port.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_din;
    end
    bus.mem_dout <= mem[bus.mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [1:0] tie_winner(input int idx);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (idx % 2 == 0) ? 2'b01 : 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  initial begin
    logic [1:0] w;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    pre_en = 1'b0; pre_addr = 16'h0000; pre_data = 16'h0000;
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_addr = 16'h0000; bus.r0_din = 16'h0000;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = 16'h0000; bus.r1_din = 16'h0000;

    tick();
    pre_en = 1'b1; pre_addr = 16'h0040; pre_data = 16'hBEEF;
    tick();
    pre_en = 1'b0;
    tick();
    rst = 1'b0;

    check("rst_busy",     {31'd0, busy},          32'd0);
    check("rst_mem_we",   {31'd0, bus.mem_we},    32'd0);
    check("rst_mem_addr", {16'd0, bus.mem_addr},  32'd0);
    check("rst_gnt",      {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);

    // Single read by r0 of 0x0040.
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 16'h0040;
    tick();
    check("rd_r0_gnt",    {31'd0, bus.r0_gnt},   32'd1);
    check("rd_r1_gnt",    {31'd0, bus.r1_gnt},   32'd0);
    check("rd_mem_addr",  {16'd0, bus.mem_addr}, 32'h0040);
    check("rd_mem_we",    {31'd0, bus.mem_we},   32'd0);
    check("rd_busy1",     {31'd0, busy},         32'd1);
    bus.r0_req = 1'b0;
    tick();
    check("rd_gnt_pulse", {31'd0, bus.r0_gnt},   32'd0);
    check("rd_busy2",     {31'd0, busy},         32'd1);
    check("rd_early_rv",  {31'd0, bus.r0_rvalid}, 32'd0);
    tick();
    check("rd_rvalid",    {31'd0, bus.r0_rvalid}, 32'd1);
    check("rd_rdata",     {16'd0, bus.r0_rdata},  32'hBEEF);
    check("rd_busy3",     {31'd0, busy},          32'd0);
    tick();
    check("rd_rv_pulse",  {31'd0, bus.r0_rvalid}, 32'd0);
    check("rd_rdata_hold", {16'd0, bus.r0_rdata}, 32'hBEEF);

    // r1 writes 0x1234 to 0x0100, then reads it back.
    bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 16'h0100; bus.r1_din = 16'h1234;
    tick();
    check("wr_r1_gnt",   {31'd0, bus.r1_gnt},   32'd1);
    check("wr_r0_gnt",   {31'd0, bus.r0_gnt},   32'd0);
    check("wr_mem_we",   {31'd0, bus.mem_we},   32'd1);
    check("wr_mem_din",  {16'd0, bus.mem_din},  32'h1234);
    check("wr_mem_addr", {16'd0, bus.mem_addr}, 32'h0100);
    bus.r1_req = 1'b0;
    tick();
    check("wr_we_off",   {31'd0, bus.mem_we},   32'd0);
    check("wr_idle",     {31'd0, busy},         32'd0);
    bus.r1_req = 1'b1; bus.r1_we = 1'b0;
    tick();
    check("rb_r1_gnt",   {31'd0, bus.r1_gnt},   32'd1);
    check("rb_mem_we",   {31'd0, bus.mem_we},   32'd0);
    bus.r1_req = 1'b0;
    tick();
    tick();
    check("rb_r1_rvalid", {31'd0, bus.r1_rvalid}, 32'd1);
    check("rb_r1_rdata",  {16'd0, bus.r1_rdata},  32'h1234);
    check("rb_r0_rvalid", {31'd0, bus.r0_rvalid}, 32'd0);
    tick();

    // Both requesters read continuously; period is three cycles per grant.
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 16'h0040;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 16'h0100;
    for (int k = 1; k <= 12; k++) begin
      tick();
      w = tie_winner((k - 1) / 3);
      check("tie_gnt",    {30'd0, bus.r1_gnt, bus.r0_gnt},       (k % 3 == 1) ? {30'd0, w} : 32'd0);
      check("tie_rvalid", {30'd0, bus.r1_rvalid, bus.r0_rvalid}, (k % 3 == 0) ? {30'd0, w} : 32'd0);
      if (k % 3 == 0) begin
        if (w == 2'b01) begin
          check("tie_r0_rdata", {16'd0, bus.r0_rdata}, 32'hBEEF);
        end else begin
          check("tie_r1_rdata", {16'd0, bus.r1_rdata}, 32'h1234);
        end
      end
    end
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b0;
    tick();
    tick();

    // Reset during CAPTURE of an r0 read.
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 16'h0040;
    tick();
    check("mr_r0_gnt", {31'd0, bus.r0_gnt}, 32'd1);
    bus.r0_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("mr_rvalid",   {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    check("mr_r0_rdata", {16'd0, bus.r0_rdata},  32'd0);
    check("mr_r1_rdata", {16'd0, bus.r1_rdata},  32'd0);
    check("mr_mem_addr", {16'd0, bus.mem_addr},  32'd0);
    check("mr_mem_din",  {16'd0, bus.mem_din},   32'd0);
    check("mr_busy",     {31'd0, busy},          32'd0);
    rst = 1'b0;
    bus.r0_req = 1'b1; bus.r1_req = 1'b1;
    tick();
    check("mr_tie_gnt", {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd1);
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    tick();
    check("mr_no_rv", {31'd0, bus.r0_rvalid}, 32'd0);
    tick();
    check("mr_rd_rvalid", {31'd0, bus.r0_rvalid}, 32'd1);
    check("mr_rd_rdata",  {16'd0, bus.r0_rdata},  32'hBEEF);
    tick();

    // r1 request rises during ISSUE of an r0 write.
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 16'h0200; bus.r0_din = 16'h5A5A;
    tick();
    check("bz_r0_gnt", {31'd0, bus.r0_gnt}, 32'd1);
    bus.r0_req = 1'b0;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 16'h0200;
    tick();
    check("bz_r1_gnt_early", {31'd0, bus.r1_gnt}, 32'd0);
    tick();
    check("bz_r1_gnt", {31'd0, bus.r1_gnt}, 32'd1);
    bus.r1_req = 1'b0;
    tick();
    tick();
    check("bz_r1_rvalid", {31'd0, bus.r1_rvalid}, 32'd1);
    check("bz_r1_rdata",  {16'd0, bus.r1_rdata},  32'h5A5A);
    check("bz_r0_rdata",  {16'd0, bus.r0_rdata},  32'hBEEF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single BRAM port A between the CPU memory interface (requester 0) and a secondary master such as a PS2 buffer writer or display reader (requester 1). It sits between the requesters and the BRAM. It serialises accesses through a small registered state machine, drives the BRAM address, data and write-enable from registers, and returns read data with a one-cycle valid pulse.

## Interface
Parameters:
- AW, 16, address width
- DW, 16, data width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- r0_req  in  1  requester 0 access request; held until r0_gnt
- r0_we  in  1  requester 0 write (1) / read (0); stable while r0_req
- r0_addr  in  AW  requester 0 address; stable while r0_req
- r0_din  in  DW  requester 0 write data; stable while r0_req
- r0_gnt  out  1  one-cycle pulse: request 0 accepted
- r0_rvalid  out  1  one-cycle pulse: r0_rdata valid
- r0_rdata  out  DW  read data for requester 0
- r1_req, r1_we, r1_addr, r1_din, r1_gnt, r1_rvalid, r1_rdata: same as r0_* for requester 1
- mem_addr  out  AW  BRAM port A address (registered)
- mem_din  out  DW  BRAM port A write data (registered)
- mem_we  out  1  BRAM port A write enable (registered)
- mem_dout  in  DW  BRAM port A read data; one-cycle latency after mem_addr
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, CAPTURE.
- **IDLE**
  - No request: stay in IDLE. mem_we is 0 and mem_addr holds its last value.
  - Any request: choose a winner and latch its addr, din and we into mem_addr, mem_din and mem_we. Set the winner's gnt for the next cycle, record `owner` and `last_gnt`, and go to ISSUE.
- **ISSUE**
  - The BRAM sees the access and gnt is high for exactly this cycle.
  - Write: go to IDLE. mem_we returns to 0 on the next edge.
  - Read: go to CAPTURE. mem_we is already 0.
- **CAPTURE**
  - mem_dout is valid. Load it into the owner's rdata register and set the owner's rvalid for the next cycle.
  - Go to IDLE.
- Requests arriving in ISSUE or CAPTURE are ignored until IDLE; requesters hold req.
- A requester that keeps req high through its gnt cycle is treated as a new request at the next IDLE sample.
- rdata registers hold their value until the next read for the same requester.
- The non-owner's gnt and rvalid are never asserted.
- Arbitration, both requesting in IDLE: see Configuration.
- Reset, on any edge with rst=1 regardless of state:
  - state returns to IDLE;
  - the in-flight access is dropped and no rvalid is produced for it;
  - registered outputs are cleared: mem_addr=0, mem_din=0, mem_we=0, gnt=0, rvalid=0, rdata=0;
  - `last_gnt` is set to 1 (requester 0 wins first);
  - busy reads 0 from the first cycle after the reset edge.

## Timing
Let E0 be the edge at which IDLE samples the request.
- Read:
  - gnt and mem_* valid in cycle E0+1 (ISSUE);
  - mem_dout valid in cycle E0+2 (CAPTURE);
  - rvalid and rdata valid in cycle E0+3.
  - Occupancy is 3 cycles; a new request can be sampled at the edge ending E0+3, concurrent with rvalid.
- Write: gnt and mem_we=1 in cycle E0+1 only. The arbiter is back in IDLE at E0+2. Occupancy is 2 cycles.
- Peak throughput, alternating requesters: one write per 2 cycles, one read per 3 cycles.
- There is no combinational path from any req to any output.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - when both requesters ask in IDLE, the winner is the one not in `last_gnt`;
  - `last_gnt` updates on every grant;
  - a single requester always wins.
- Not defined:
  - fixed priority, requester 0 (CPU) always wins a tie;
  - `last_gnt` is still maintained but unused;
  - requester 1 may starve.

## Test plan
- Reset then single read: mem[0x0040]=0xBEEF, r0 reads 0x0040.
  - Required: r0_gnt at E0+1 with mem_addr=0x0040, mem_we=0; r0_rvalid=1 and r0_rdata=0xBEEF at E0+3; busy high E0+1..E0+2.
- Write then readback: r1 writes 0x1234 to 0x0100, then reads 0x0100.
  - Required: mem_we=1 for exactly one cycle with mem_din=0x1234.
  - Required: the read returns r1_rdata=0x1234 with r1_rvalid, and no r0_rvalid.
- Tie, both requesting reads continuously with the macro defined:
  - Required: grants alternate r0, r1, r0, r1 and each rvalid goes to the matching requester.
- Same tie without the macro:
  - Required: r0 is granted every time and r1_gnt stays 0 while r0_req is held.
- Reset mid-read: assert rst in CAPTURE of an r0 read.
  - Required: no r0_rvalid pulse; all outputs 0 the next cycle; the first following tie grants r0.
- Request during busy: r1_req rises in the ISSUE cycle of an r0 write.
  - Required: r1 is sampled in the next IDLE and r1_gnt is asserted 2 cycles after r0_gnt.
